// File: rtl/alu_secuencial.sv
// EX-stage execution unit: single-cycle ALU ops plus a bit-serial SLL.
// start/busy/done handshake toward the controller; result/zero/illegal are registered on done.
module alu_secuencial #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         alu_code,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1111;

   state_t             state, state_next;
   logic [3:0]         code_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [SHAMT_W-1:0] cnt;
   logic [WIDTH-1:0]   alu_value;
   logic               alu_illegal;
   logic               finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      finish     = 1'b0;
      case (state)
         IDLE:  if (start) state_next = (alu_code == OP_SLL) ? SHIFT : EXEC;
         EXEC: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         SHIFT: if (cnt == '0) begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb busy = (state != IDLE);

   always_comb begin
      alu_value   = '0;
      alu_illegal = 1'b0;
      case (code_reg)
         OP_ADD: alu_value = a_reg + b_reg;
         OP_SUB: alu_value = a_reg - b_reg;
         OP_AND: alu_value = a_reg & b_reg;
         OP_OR:  alu_value = a_reg | b_reg;
         OP_NOR: alu_value = ~(a_reg | b_reg);
         OP_SLT: alu_value[0] = ($signed(a_reg) < $signed(b_reg));
         default: alu_illegal = 1'b1;
      endcase
   end

   // b_reg doubles as the shift working register; shifting past WIDTH drains it to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_reg <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b1;
         illegal  <= 1'b0;
      end else begin
         done <= finish;
         case (state)
            IDLE: if (start) begin
               code_reg <= alu_code;
               a_reg    <= op_a;
               b_reg    <= op_b;
               cnt      <= shamt;
            end
            EXEC: begin
               result  <= alu_value;
               zero    <= (alu_value == '0);
               illegal <= alu_illegal;
            end
            SHIFT: begin
               if (cnt != '0) begin
                  b_reg <= b_reg << 1;
                  cnt   <= cnt - SHAMT_W'(1);
               end else begin
                  result  <= b_reg;
                  zero    <= (b_reg == '0);
                  illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial: directed cases then randomized ops against a reference model.
module tb_alu_secuencial;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  alu_code = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  shamt = '0;
   logic        busy, done, zero, illegal;
   logic [31:0] result;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] exp_result = '0;
   logic        exp_zero = 1'b1;
   logic        exp_illegal = 1'b0;

   alu_secuencial #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_code(alu_code),
      .op_a(op_a), .op_b(op_b), .shamt(shamt),
      .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {illegal, result} from the operation table.
   function automatic logic [32:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] r;
      logic        bad;
      r   = 32'h0;
      bad = 1'b0;
      case (code)
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0111: r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, (a < b)};
         4'b1111: r = b << sh;
         default: bad = 1'b1;
      endcase
      return {bad, r};
   endfunction

   task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
      logic [32:0] r;
      int unsigned lat;
      int unsigned cycles;
      r   = ref_alu(code, a, b, sh);
      lat = (code == 4'b1111) ? int'(sh) + 1 : 1;
      @(negedge clk);
      alu_code = code; op_a = a; op_b = b; shamt = sh; start = 1'b1;
      @(posedge clk); #1;
      check("accept_busy", {31'h0, busy}, 32'h1);
      check("accept_done", {31'h0, done}, 32'h0);
      cycles = 0;
      while (done !== 1'b1 && cycles < 100) begin
         check("hold_result", result, exp_result);
         check("busy_during", {31'h0, busy}, 32'h1);
         // Garbage on every input while busy: start must be ignored, latched copies used.
         start    = 1'($urandom);
         alu_code = 4'($urandom);
         op_a     = $urandom;
         op_b     = $urandom;
         shamt    = 5'($urandom);
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      exp_result  = r[31:0];
      exp_illegal = r[32];
      exp_zero    = (r[31:0] == 32'h0);
      check("latency", cycles, lat);
      check("result", result, exp_result);
      check("zero", {31'h0, zero}, {31'h0, exp_zero});
      check("illegal", {31'h0, illegal}, {31'h0, exp_illegal});
      check("busy_at_done", {31'h0, busy}, 32'h0);
   endtask

   logic [3:0] codes [8];

   initial begin
      codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111, 4'b1010};

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_result", result, 32'h0);
      check("rst_zero", {31'h0, zero}, 32'h1);
      check("rst_illegal", {31'h0, illegal}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(4'b0010, 32'h0000_0005, 32'h0000_0003, 5'd0);
      run_op(4'b0110, 32'h0000_0007, 32'h0000_0007, 5'd0);
      run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
      run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
      run_op(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
      run_op(4'b1100, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd0);
      run_op(4'b1111, 32'h0000_0001, 32'h0000_0001, 5'd31);
      run_op(4'b1111, 32'h0000_0000, 32'h1234_5678, 5'd0);
      run_op(4'b1010, 32'h0000_0005, 32'h0000_0003, 5'd0);
      run_op(4'b0000, 32'h0000_00F0, 32'h0000_003C, 5'd0);

      // Reset in the middle of a shift.
      @(negedge clk);
      alu_code = 4'b1111; op_b = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_result", result, 32'h0);
      check("abort_zero", {31'h0, zero}, 32'h1);
      check("abort_illegal", {31'h0, illegal}, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_no_done", {31'h0, done}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_result = 32'h0; exp_zero = 1'b1; exp_illegal = 1'b0;
      run_op(4'b0010, 32'h0000_0001, 32'h0000_0001, 5'd0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
         run_op(c, $urandom, $urandom, 5'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
